// File: rtl/bram_frame_streamer.sv
// Streams one FRAME_LEN-word frame from a 1-cycle-latency BRAM as an AXI4-Stream master.
// A 2-entry FIFO absorbs the read latency, so backpressure never drops or repeats a word.
module bram_frame_streamer #(
    parameter int DATA_W    = 20,
    parameter int ADDR_W    = 10,
    parameter int FRAME_LEN = 786
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);
    // Counters are one bit wider than the address so FRAME_LEN == 2^ADDR_W is representable.
    localparam logic [ADDR_W:0] LEN_C  = (ADDR_W+1)'(FRAME_LEN);
    localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(FRAME_LEN - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] addr_hold_reg;
    logic [ADDR_W:0]   issue_cnt_reg;
    logic [ADDR_W:0]   beat_cnt_reg;
    logic              rd_pending_reg;
    logic              rd_ptr_reg;
    logic              wr_ptr_reg;
    logic [1:0]        fifo_count_reg;
    logic [DATA_W-1:0] fifo_mem_reg [2];
    logic              busy_reg;
    logic              done_reg;

    logic              pop;
    logic              issue;
    logic              last_beat;
    logic [1:0]        occupancy;
    logic [ADDR_W-1:0] issue_addr;

    assign m_axis_tvalid = (fifo_count_reg != 2'd0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign last_beat     = (beat_cnt_reg == LAST_C);
    assign occupancy     = fifo_count_reg + {1'b0, rd_pending_reg};
    assign issue_addr    = base_reg + issue_cnt_reg[ADDR_W-1:0];

    // A read may be issued into a full pipeline only when a word leaves it in the same cycle.
    assign issue = (state_reg == RUN) && (issue_cnt_reg < LEN_C) &&
                   ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));

    assign bram_en      = issue;
    assign bram_addr    = issue ? issue_addr : addr_hold_reg;
    assign m_axis_tdata = fifo_mem_reg[rd_ptr_reg];
    assign m_axis_tlast = m_axis_tvalid && last_beat;
    assign busy         = busy_reg;
    assign done         = done_reg;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            addr_hold_reg  <= '0;
            issue_cnt_reg  <= '0;
            beat_cnt_reg   <= '0;
            rd_pending_reg <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            wr_ptr_reg     <= 1'b0;
            fifo_count_reg <= 2'd0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg       <= 1'b0;
            rd_pending_reg <= issue;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        base_reg      <= base_addr;
                        issue_cnt_reg <= '0;
                        beat_cnt_reg  <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        issue_cnt_reg <= issue_cnt_reg + 1'b1;
                        addr_hold_reg <= issue_addr;
                    end
                    if (pop) begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        if (last_beat) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (rd_pending_reg) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)            rd_ptr_reg <= ~rd_ptr_reg;
            case ({rd_pending_reg, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + 2'd1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 2'd1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    // Read data lands in the slot addressed by the write pointer one cycle after its issue.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    fifo_mem_reg[gi] <= '0;
                end else if (rd_pending_reg && (wr_ptr_reg == 1'(gi))) begin
                    fifo_mem_reg[gi] <= bram_rdata;
                end
            end
        end
    endgenerate

    assert property (@(posedge aclk) disable iff (!aresetn)
                     !(rd_pending_reg && (fifo_count_reg == 2'd2) && !pop));

endmodule
